// File: rtl/hoaaned_pkg.sv
// Shared constants and helper functions for the HOAANED pipelined adder.
// Holds the clamp for the lower-part length and the variable-k approximate lower sum.
package hoaaned_pkg;

  localparam int unsigned LPL_MAX_DEF = 6;
  localparam int unsigned K_W         = $clog2(LPL_MAX_DEF + 1);
  localparam int unsigned LOW_CAP     = 32;

  function automatic int unsigned clamp_lpl(input int unsigned lpl, input int unsigned lpl_max);
    return (lpl > lpl_max) ? lpl_max : lpl;
  endfunction

  // Returns {c, sum[LOW_CAP-1:0]}; bits at and above k are zero, k < 2 yields all zeros.
  function automatic logic [LOW_CAP:0] hoaaned_lower(input logic [LOW_CAP-1:0] a,
                                                     input logic [LOW_CAP-1:0] b,
                                                     input int unsigned        k);
    logic [LOW_CAP-1:0] hi_bit;
    logic [LOW_CAP-1:0] mid_bit;
    logic [LOW_CAP-1:0] s;
    logic               c;
    logic               top;
    hi_bit  = '0;
    mid_bit = '0;
    s       = '0;
    c       = 1'b0;
    top     = 1'b0;
    if (k >= 2 && k <= LOW_CAP) begin
      hi_bit  = LOW_CAP'(1) << (k - 1);
      mid_bit = hi_bit >> 1;
      c       = |(a & b & hi_bit);
      top     = (!c && (|((a | b) & hi_bit))) || (|(a & b & mid_bit));
      s       = (mid_bit - LOW_CAP'(1)) | ((a | b) & mid_bit) | (top ? hi_bit : '0);
    end
    return {c, s};
  endfunction

endpackage

// File: rtl/hoaaned_pipe_adder_lower_approx.sv
// Combinational HOAANED lower part for a runtime lower-part length k.
// Inputs are the LPL_MAX low operand bits; sum bits at and above k are zero.
module hoaaned_lower_approx
  import hoaaned_pkg::*;
#(
  parameter  int unsigned LPL_MAX = LPL_MAX_DEF,
  localparam int unsigned LPL_W   = $clog2(LPL_MAX + 1)
) (
  input  logic [LPL_MAX-1:0] a,
  input  logic [LPL_MAX-1:0] b,
  input  logic [LPL_W-1:0]   k,
  output logic [LPL_MAX-1:0] sum,
  output logic               c
);

  logic [LOW_CAP:0] res;

  assign res = hoaaned_lower(LOW_CAP'(a), LOW_CAP'(b), 32'(k));
  assign sum = LPL_MAX'(res);
  assign c   = res[LOW_CAP];

endmodule

// File: rtl/hoaaned_pipe_adder.sv
// Two-stage valid/ready adder with selectable HOAANED approximate lower part
// and an exact-reference error monitor (mismatch count and maximum error).
module hoaaned_pipe_adder
  import hoaaned_pkg::*;
#(
  parameter  int unsigned N       = 16,
  parameter  int unsigned LPL_MAX = LPL_MAX_DEF,
  parameter  int unsigned ERR_W   = 16,
  localparam int unsigned LPL_W   = $clog2(LPL_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             cfg_approx,
  input  logic [LPL_W-1:0] cfg_lpl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       out_sum,
  output logic [N:0]       out_err,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N:0]       err_max
);

  localparam int unsigned SW = N + 1;

  logic [LPL_W-1:0]   k;
  logic [N-1:0]       lo_mask;
  logic [LPL_MAX-1:0] ap_lo;
  logic               ap_c;
  logic [SW-1:0]      ex_lo_full;
  logic               ex_c;
  logic               take;
  logic               s2_load;

  logic               s1_valid;
  logic [LPL_W-1:0]   s1_k;
  logic [N-1:0]       s1_lo;
  logic               s1_c;
  logic [N-1:0]       s1_a_hi;
  logic [N-1:0]       s1_b_hi;
  logic [N-1:0]       s1_ex_lo;
  logic               s1_ex_c;

  logic [SW-1:0]      sum_ap;
  logic [SW-1:0]      sum_ex;
  logic [SW-1:0]      diff;

  // Effective split point; k = 0 collapses both paths to a plain exact add.
  always_comb begin
    k = '0;
    if (cfg_approx && clamp_lpl(32'(cfg_lpl), LPL_MAX) >= 2)
      k = LPL_W'(clamp_lpl(32'(cfg_lpl), LPL_MAX));
  end

  assign lo_mask    = (N'(1) << k) - N'(1);
  assign ex_lo_full = SW'(in_a & lo_mask) + SW'(in_b & lo_mask);
  assign ex_c       = |(ex_lo_full & (SW'(1) << k));

  hoaaned_lower_approx #(.LPL_MAX(LPL_MAX)) u_lower (
    .a   (in_a[LPL_MAX-1:0]),
    .b   (in_b[LPL_MAX-1:0]),
    .k   (k),
    .sum (ap_lo),
    .c   (ap_c)
  );

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign take     = in_valid && in_ready;
  assign s2_load  = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_ex_lo <= '0;
      s1_ex_c  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (take) begin
        s1_k     <= k;
        s1_lo    <= N'(ap_lo);
        s1_c     <= ap_c;
        s1_a_hi  <= in_a >> k;
        s1_b_hi  <= in_b >> k;
        s1_ex_lo <= N'(ex_lo_full) & lo_mask;
        s1_ex_c  <= ex_c;
      end
    end
  end

  // Upper parts share the aligned operands; only the carry-in and lower bits differ.
  assign sum_ap = ((SW'(s1_a_hi) + SW'(s1_b_hi) + SW'(s1_c)) << s1_k) | SW'(s1_lo);
  assign sum_ex = ((SW'(s1_a_hi) + SW'(s1_b_hi) + SW'(s1_ex_c)) << s1_k) | SW'(s1_ex_lo);
  assign diff   = (sum_ex >= sum_ap) ? (sum_ex - sum_ap) : (sum_ap - sum_ex);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= sum_ap;
        out_err <= diff;
      end
    end
  end

  // Monitor advances on the output handshake; clear wins over a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err != '0 && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (out_err > err_max) err_max <= out_err;
    end
  end

endmodule

// File: tb/tb_hoaaned_pipe_adder.sv
// Directed self-checking bench for hoaaned_pipe_adder (N=16, LPL_MAX=6, ERR_W=2).
module tb_hoaaned_pipe_adder;
  import hoaaned_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_a;
  logic [15:0]    in_b;
  logic           cfg_approx;
  logic [K_W-1:0] cfg_lpl;
  logic           out_valid;
  logic           out_ready;
  logic [16:0]    out_sum;
  logic [16:0]    out_err;
  logic           err_clr;
  logic [1:0]     err_cnt;
  logic [16:0]    err_max;

  int tests;
  int fails;

  hoaaned_pipe_adder #(.N(16), .LPL_MAX(6), .ERR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .cfg_approx (cfg_approx),
    .cfg_lpl    (cfg_lpl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
    .err_max    (err_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat: accept, confirm 2-cycle latency, check result, then handshake.
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ap, input logic [K_W-1:0] lpl,
                          input logic [16:0] es, input logic [16:0] ee, input logic clr);
    in_a = a; in_b = b; cfg_approx = ap; cfg_lpl = lpl; in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_approx = ~ap; cfg_lpl = '0;
    check({tag, ".lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"}, 32'(out_sum), 32'(es));
    check({tag, ".err"}, 32'(out_err), 32'(ee));
    err_clr = clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int tx, rx, cyc;
    logic [16:0] exp_sum;
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; cfg_approx = 1'b0;
    cfg_lpl = '0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_sum", 32'(out_sum), 32'd0);
    check("rst.out_err", 32'(out_err), 32'd0);
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
    check("rst.err_max", 32'(err_max), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    send_one("v1", 16'h0025, 16'h001A, 1'b1, 3'd6, 17'h0003F, 17'h0, 1'b0);
    check("v1.cnt", 32'(err_cnt), 32'd0);
    check("v1.max", 32'(err_max), 32'd0);
    send_one("v2", 16'h0030, 16'h0030, 1'b1, 3'd6, 17'h0007F, 17'h1F, 1'b0);
    check("v2.cnt", 32'(err_cnt), 32'd1);
    check("v2.max", 32'(err_max), 32'h1F);
    send_one("v3ap", 16'hFFFF, 16'hFFFF, 1'b1, 3'd6, 17'h1FFFF, 17'h1, 1'b0);
    check("v3ap.cnt", 32'(err_cnt), 32'd2);
    check("v3ap.max", 32'(err_max), 32'h1F);
    send_one("v3ex", 16'hFFFF, 16'hFFFF, 1'b0, 3'd6, 17'h1FFFE, 17'h0, 1'b0);
    check("v3ex.cnt", 32'(err_cnt), 32'd2);
    // lpl=7 clamps to 6; k=7 would give 0xFF / 0x3F instead
    send_one("clamp7", 16'h0060, 16'h0060, 1'b1, 3'd7, 17'h000CF, 17'h0F, 1'b0);
    check("clamp7.cnt", 32'(err_cnt), 32'd3);
    check("clamp7.max", 32'(err_max), 32'h1F);
    send_one("lpl1", 16'h0060, 16'h0060, 1'b1, 3'd1, 17'h000C0, 17'h0, 1'b0);
    check("lpl1.cnt", 32'(err_cnt), 32'd3);
    send_one("lpl2", 16'h0003, 16'h0003, 1'b1, 3'd2, 17'h00007, 17'h1, 1'b0);
    check("lpl2.cnt_sat", 32'(err_cnt), 32'd3);
    // approximate result below exact: 0x3F vs 0x40
    send_one("under", 16'h0030, 16'h0010, 1'b1, 3'd6, 17'h0003F, 17'h1, 1'b0);
    check("under.cnt_sat", 32'(err_cnt), 32'd3);
    check("under.max", 32'(err_max), 32'h1F);
    send_one("clr", 16'h0030, 16'h0030, 1'b1, 3'd6, 17'h0007F, 17'h1F, 1'b1);
    check("clr.cnt", 32'(err_cnt), 32'd0);
    check("clr.max", 32'(err_max), 32'd0);
    send_one("post", 16'h0060, 16'h0060, 1'b1, 3'd6, 17'h000CF, 17'h0F, 1'b0);
    check("post.cnt", 32'(err_cnt), 32'd1);
    check("post.max", 32'(err_max), 32'h0F);

    // 8 back-to-back exact beats, sum = 0x1000 + 0x12*i, with a 3-cycle output stall
    tx = 0; rx = 0; cyc = 0;
    while (rx < 8 && cyc < 40) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      if (tx < 8) begin
        in_valid = 1'b1; in_a = 16'h1000 + 16'(tx); in_b = 16'(tx) * 16'h0011;
        cfg_approx = 1'b0; cfg_lpl = 3'd6;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) check("stream.stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid) begin
        exp_sum = 17'h01000 + 17'(rx) * 17'h00012;
        if (rx < 8) begin
          check("stream.sum", 32'(out_sum), 32'(exp_sum));
          check("stream.err", 32'(out_err), 32'd0);
        end else begin
          check("stream.extra_beat", 32'(rx), 32'd7);
        end
        if (out_ready) rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream.rx_count", 32'(rx), 32'd8);
    check("stream.tx_count", 32'(tx), 32'd8);
    check("stream.drained", 32'(out_valid), 32'd0);

    // reset with two beats in flight
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0002; cfg_approx = 1'b0;
    @(posedge clk); #1;
    in_a = 16'h0003; in_b = 16'h0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstmid.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.out_sum", 32'(out_sum), 32'd0);
    check("rstmid.err_cnt", 32'(err_cnt), 32'd0);
    check("rstmid.err_max", 32'(err_max), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstmid.no_stale", 32'(out_valid), 32'd0);
    end
    check("rstmid.in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
